// File: rtl/booth_seq_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Booth pair codes on {Q[0], q_m1}
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    // Iteration counter must hold the value WIDTH
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/booth_seq_mpy_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A,
// then arithmetic right shift of {A, Q, q_m1}. Purely combinational.
module booth_step
    import booth_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             qm1_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] q_o,
    output logic             qm1_o
);

    logic [WIDTH:0] sum;

    // Select add, subtract or pass-through, then shift right with sign fill
    always_comb begin
        sum = acc_i;
        unique case ({q_i[0], qm1_i})
            BOOTH_ADD: sum = acc_i + m_i;
            BOOTH_SUB: sum = acc_i - m_i;
            default:   sum = acc_i;
        endcase
        acc_o = {sum[WIDTH], sum[WIDTH:1]};
        q_o   = {sum[0], q_i[WIDTH-1:1]};
        qm1_o = q_i[0];
    end

endmodule

// File: rtl/booth_seq_mpy.sv
// Sequential radix-2 Booth multiplier controller with start/busy/done
// handshake. Optional build macro BOOTH_ZERO_BYPASS_EN: a request with a
// zero operand skips RUN and completes with p=0 one edge after acceptance.
module booth_seq_mpy
    import booth_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t             state_q;
    logic [WIDTH:0]     m_q;
    logic [WIDTH:0]     acc_q;
    logic [WIDTH-1:0]   q_q;
    logic               qm1_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [2*WIDTH-1:0] p_q;

    logic [WIDTH:0]     acc_d;
    logic [WIDTH-1:0]   q_d;
    logic               qm1_d;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i (acc_q),
        .q_i   (q_q),
        .qm1_i (qm1_q),
        .m_i   (m_q),
        .acc_o (acc_d),
        .q_o   (q_d),
        .qm1_o (qm1_d)
    );

    // Control FSM and datapath registers; reset aborts any operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            p_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        m_q   <= {a[WIDTH-1], a};
                        acc_q <= '0;
                        q_q   <= b;
                        qm1_q <= 1'b0;
                        cnt_q <= CW'(WIDTH);
`ifdef BOOTH_ZERO_BYPASS_EN
                        if (a == '0 || b == '0) begin
                            p_q     <= '0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
`else
                        busy_q  <= 1'b1;
                        state_q <= RUN;
`endif
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    qm1_q <= qm1_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        p_q     <= {acc_d[WIDTH-1:0], q_d};
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;

endmodule

// File: tb/tb_booth_seq_mpy.sv
// Directed self-checking bench for booth_seq_mpy at WIDTH=4.
module tb_booth_seq_mpy;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       busy;
    logic       done;
    logic [7:0] p;

    int total = 0;
    int bad = 0;
    bit overlap = 1'b0;

    always #5 clk = ~clk;

    booth_seq_mpy #(
        .WIDTH (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) at falling edges until the block is back in IDLE
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || done) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("idle_timeout", 32'd0, 32'd1);
    endtask

    // One request; lat counts edges from acceptance (inclusive) to done
    task automatic run_op(input logic [3:0] ai, input logic [3:0] bi,
                          output logic [7:0] pr, output int lat, output int bc);
        int i;
        wait_idle();
        a = ai;
        b = bi;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bc = 0;
        i = 1;
        while (!done && i <= 20) begin
            if (busy) bc++;
            @(posedge clk);
            #1;
            if (busy && done) overlap = 1'b1;
            i++;
        end
        lat = (i > 20) ? 99 : i;
        pr = p;
    endtask

    logic [7:0] pr;
    int         lat;
    int         bc;
    int         ia;
    int         ib;
    int         exp_lat;
    int         ndone;
    int         tdone [8];

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_p", 32'(p), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 3 * -2
        run_op(4'd3, 4'hE, pr, lat, bc);
        check("basic_p", 32'(pr), 32'h0FA);
        check("basic_lat", 32'(lat), 32'd5);
        check("basic_busy_cycles", 32'(bc), 32'd4);
        repeat (3) @(posedge clk);
        #1;
        check("basic_hold", 32'(p), 32'h0FA);

        // Corners
        run_op(4'h8, 4'h8, pr, lat, bc);
        check("m8_m8", 32'(pr), 32'h040);
        run_op(4'h8, 4'h7, pr, lat, bc);
        check("m8_p7", 32'(pr), 32'h0C8);
        run_op(4'h7, 4'h7, pr, lat, bc);
        check("p7_p7", 32'(pr), 32'h031);

        // Exhaustive sweep against integer reference
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                ia = $signed(4'(i));
                ib = $signed(4'(j));
`ifdef BOOTH_ZERO_BYPASS_EN
                exp_lat = (i == 0 || j == 0) ? 1 : 5;
`else
                exp_lat = 5;
`endif
                run_op(4'(i), 4'(j), pr, lat, bc);
                check("sweep_p", {16'(i), 8'(j), pr}, {16'(i), 8'(j), 8'(ia * ib)});
                check("sweep_lat", 32'(lat), 32'(exp_lat));
            end
        end

        // Start during RUN is ignored
        wait_idle();
        a = 4'd5;
        b = 4'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 4'd1;
        b = 4'd1;
        start = 1'b1;
        begin
            int n;
            n = 0;
            while (!done && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            start = 1'b0;
            check("ignore_done_seen", 32'(done), 32'd1);
        end
        check("ignore_p", 32'(p), 32'h00F);

        // Reset during the second RUN cycle
        wait_idle();
        a = 4'd5;
        b = 4'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_p", 32'(p), 32'd0);
        rst = 1'b0;
        run_op(4'd2, 4'd3, pr, lat, bc);
        check("after_abort_p", 32'(pr), 32'h006);
        check("after_abort_lat", 32'(lat), 32'd5);

        // Start held high: repeated -1 * -1 every W+2 cycles
        wait_idle();
        a = 4'hF;
        b = 4'hF;
        start = 1'b1;
        ndone = 0;
        for (int k = 0; k < 8; k++) tdone[k] = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (busy && done) overlap = 1'b1;
            if (done) begin
                check("held_p", 32'(p), 32'h001);
                if (ndone < 8) tdone[ndone] = c;
                ndone++;
            end
        end
        start = 1'b0;
        check("held_count", 32'(ndone >= 3), 32'd1);
        check("held_period1", 32'(tdone[1] - tdone[0]), 32'd6);
        check("held_period2", 32'(tdone[2] - tdone[1]), 32'd6);

        // Zero operand
        run_op(4'd0, 4'd5, pr, lat, bc);
        check("zero_p", 32'(pr), 32'd0);
`ifdef BOOTH_ZERO_BYPASS_EN
        check("zero_lat", 32'(lat), 32'd1);
        check("zero_busy_cycles", 32'(bc), 32'd0);
`else
        check("zero_lat", 32'(lat), 32'd5);
        check("zero_busy_cycles", 32'(bc), 32'd4);
`endif

        check("busy_done_overlap", 32'(overlap), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
